imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/npc_pkg.sv | 25 ++
 rtl/imem_array.sv | 23 ++
 rtl/imem_responder.sv | 92 +++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared fetch-side constants and the responder state type.
// Also holds the fetch address error check.
package npc_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Addresses below base wrap to a huge offset and so fall out of range.
  function automatic logic fetch_err(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned depth
  );
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction store: synchronous write, combinational read.
// Contents are deliberately not reset.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction fetch responder with fixed latency and preload port.
// Error and NOP substitution are derived from the captured address.
module imem_responder
  import npc_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1,
  parameter logic [31:0] BASE    = RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int AW = $clog2(DEPTH);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, inst_q;
  logic [31:0] rdata;
  logic [AW-1:0] ridx;
  logic        accept;

  assign ridx   = AW'((req_addr - BASE) >> 2);
  assign accept = req_valid & req_ready;

  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (ridx),
    .rdata (rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else cnt_d = cnt_q - 3'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        req_ready  = resp_ready;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (LATENCY == 1) begin
        state_d = RESP;
      end else begin
        state_d = WAIT;
        cnt_d   = 3'(LATENCY - 2);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= BASE;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= req_addr;
        inst_q <= rdata;
      end
    end
  end

  assign resp_err  = fetch_err(addr_q, BASE, DEPTH);
  assign resp_inst = resp_err ? INST_NOP : inst_q;

endmodule
